// File: rtl/freq_meas_ctrl.sv
// Frequency-meter measurement controller.
// Sequences clear / gate / settle / decide / latch / hold for a BCD count
// datapath, and auto-ranges the gate length between GATE_CYCLES, /10 and /100.
// All outputs are registered and decoded from the next state, so each output
// lines up exactly with the state it belongs to.
module freq_meas_ctrl #(
    parameter int unsigned GATE_CYCLES   = 50000000,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       cnt_ovf,
    input  logic       cnt_low,
    output logic       cnt_clr,
    output logic       cnt_en,
    output logic       cnt_latch,
    output logic [1:0] range,
    output logic       meas_valid,
    output logic       overrange,
    output logic       busy
);

    localparam int unsigned TIMER_W = 28;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_GATE,
        S_SETTLE,
        S_DECIDE,
        S_LATCH,
        S_HOLD
    } state_t;

    localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(HOLD_CYCLES - 1);

    state_t               state_reg, state_next;
    logic [TIMER_W-1:0]   timer_reg, timer_next;
    logic [1:0]           range_reg, range_next;
    logic                 up_flag_reg, up_flag_next;
    logic                 overrange_reg, overrange_next;

    logic                 cnt_clr_reg;
    logic                 cnt_en_reg;
    logic                 cnt_latch_reg;
    logic                 meas_valid_reg;
    logic                 busy_reg;

    // Terminal count of the gate timer for each range. Entry 3 is never
    // selected (range tops out at 2) but keeps the table fully populated.
    logic [TIMER_W-1:0]   gate_last_tab [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_gate_len
            localparam int unsigned EXP = (gi > 2) ? 2 : gi;
            localparam int unsigned LEN = GATE_CYCLES / (10 ** EXP);
            assign gate_last_tab[gi] = TIMER_W'(LEN - 1);
        end
    endgenerate

    // State, timer and range bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            timer_reg     <= '0;
            range_reg     <= 2'd0;
            up_flag_reg   <= 1'b0;
            overrange_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            range_reg     <= range_next;
            up_flag_reg   <= up_flag_next;
            overrange_reg <= overrange_next;
        end
    end

    // Next-state logic: phase timing via a single down-counting timer that is
    // reloaded on each timed phase entry and never allowed to wrap.
    always_comb begin
        state_next     = state_reg;
        timer_next     = timer_reg;
        range_next     = range_reg;
        up_flag_next   = up_flag_reg;
        overrange_next = overrange_reg;

        case (state_reg)
            S_IDLE: begin
                if (run) begin
                    state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_next = S_GATE;
                timer_next = gate_last_tab[range_reg];
            end
            S_GATE: begin
                if (timer_reg == '0) begin
                    state_next = S_SETTLE;
                    timer_next = SETTLE_LAST;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            S_SETTLE: begin
                if (timer_reg == '0) begin
                    state_next = S_DECIDE;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            S_DECIDE: begin
                // Overflow wins over low count; up_flag blocks a down-step
                // after an up-step so one measurement cannot oscillate.
                if (cnt_ovf && range_reg < 2'd2) begin
                    range_next   = range_reg + 2'd1;
                    up_flag_next = 1'b1;
                    state_next   = S_CLEAR;
                end else if (cnt_ovf) begin
                    overrange_next = 1'b1;
                    up_flag_next   = 1'b0;
                    state_next     = S_LATCH;
                end else if (cnt_low && range_reg > 2'd0 && !up_flag_reg) begin
                    range_next = range_reg - 2'd1;
                    state_next = S_CLEAR;
                end else begin
                    overrange_next = 1'b0;
                    up_flag_next   = 1'b0;
                    state_next     = S_LATCH;
                end
            end
            S_LATCH: begin
                state_next = S_HOLD;
                timer_next = HOLD_LAST;
            end
            S_HOLD: begin
                if (timer_reg == '0) begin
                    state_next = run ? S_CLEAR : S_IDLE;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Registered Moore outputs decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_clr_reg    <= 1'b0;
            cnt_en_reg     <= 1'b0;
            cnt_latch_reg  <= 1'b0;
            meas_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            cnt_clr_reg    <= (state_next == S_CLEAR);
            cnt_en_reg     <= (state_next == S_GATE);
            cnt_latch_reg  <= (state_next == S_LATCH);
            meas_valid_reg <= (state_next == S_LATCH);
            busy_reg       <= (state_next != S_IDLE);
        end
    end

    assign cnt_clr    = cnt_clr_reg;
    assign cnt_en     = cnt_en_reg;
    assign cnt_latch  = cnt_latch_reg;
    assign meas_valid = meas_valid_reg;
    assign busy       = busy_reg;
    assign range      = range_reg;
    assign overrange  = overrange_reg;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Bench for freq_meas_ctrl: directed scenarios plus randomized decide inputs,
// checked against a measurement-level reference model of the ranging rules.
module tb_freq_meas_ctrl;

    localparam int GATE   = 100;
    localparam int SETTLE = 2;
    localparam int HOLD   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       cnt_ovf;
    logic       cnt_low;
    logic       cnt_clr;
    logic       cnt_en;
    logic       cnt_latch;
    logic [1:0] range;
    logic       meas_valid;
    logic       overrange;
    logic       busy;

    freq_meas_ctrl #(
        .GATE_CYCLES  (GATE),
        .SETTLE_CYCLES(SETTLE),
        .HOLD_CYCLES  (HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .cnt_ovf   (cnt_ovf),
        .cnt_low   (cnt_low),
        .cnt_clr   (cnt_clr),
        .cnt_en    (cnt_en),
        .cnt_latch (cnt_latch),
        .range     (range),
        .meas_valid(meas_valid),
        .overrange (overrange),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int mv_count  = 0;

    // Reference model: measurement-level state only.
    int m_range = 0;
    bit m_up    = 1'b0;
    bit m_ovr   = 1'b0;
    int m_pub   = 0;

    always @(negedge clk) begin
        if (meas_valid === 1'b1) mv_count++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One measurement attempt, entered on a cnt_clr cycle. Drives the decide
    // inputs during SETTLE, noise elsewhere, and checks timing and outcome.
    task automatic attempt(input bit ovf, input bit low, input bit drop_run);
        int g;
        int len;
        bit publish;
        g = GATE;
        for (int k = 0; k < m_range; k++) g = g / 10;

        chk("clr_pulse", cnt_clr, 1);
        chk("clr_range", range, m_range);
        chk("clr_en", cnt_en, 0);
        cnt_ovf = 1'($urandom);
        cnt_low = 1'($urandom);
        step();
        chk("clr_width", cnt_clr, 0);

        len = 0;
        while (cnt_en === 1'b1 && len < 2 * GATE) begin
            len++;
            if (drop_run && len == 3) run = 1'b0;
            if (meas_valid !== 1'b0) chk("gate_no_valid", meas_valid, 0);
            cnt_ovf = 1'($urandom);
            cnt_low = 1'($urandom);
            step();
        end
        chk("gate_len", len, g);

        // First SETTLE cycle: present the datapath verdict.
        cnt_ovf = ovf;
        cnt_low = low;
        step(SETTLE);
        chk("decide_busy", busy, 1);
        chk("decide_en", cnt_en, 0);
        step();

        if (ovf && m_range < 2) begin
            m_range++;
            m_up    = 1'b1;
            publish = 1'b0;
        end else if (ovf) begin
            m_ovr   = 1'b1;
            publish = 1'b1;
        end else if (low && m_range > 0 && !m_up) begin
            m_range--;
            publish = 1'b0;
        end else begin
            m_ovr   = 1'b0;
            publish = 1'b1;
        end
        cnt_ovf = 1'($urandom);
        cnt_low = 1'($urandom);

        chk("latch", cnt_latch, publish);
        chk("meas_valid", meas_valid, publish);
        chk("retry_clr", cnt_clr, !publish);
        chk("range", range, m_range);
        chk("overrange", overrange, m_ovr);
        $display("attempt ovf=%0d low=%0d gate=%0d publish=%0d range=%0d overrange=%0d",
                 ovf, low, len, publish, range, overrange);

        if (publish) begin
            m_up = 1'b0;
            m_pub++;
            for (int h = 0; h < HOLD; h++) begin
                step();
                chk("hold_busy", busy, 1);
                chk("hold_clr", cnt_clr, 0);
            end
            step();
            chk("exit_clr", cnt_clr, run);
            chk("exit_busy", busy, run);
            chk("valid_count", mv_count, m_pub);
        end
    endtask

    initial begin
        int t0;
        bit r_ovf;
        bit r_low;

        // Reset and idle
        rst     = 1'b1;
        run     = 1'b0;
        cnt_ovf = 1'b0;
        cnt_low = 1'b0;
        step(3);
        rst = 1'b0;
        chk("rst_clr", cnt_clr, 0);
        chk("rst_en", cnt_en, 0);
        chk("rst_latch", cnt_latch, 0);
        chk("rst_range", range, 0);
        chk("rst_valid", meas_valid, 0);
        chk("rst_ovr", overrange, 0);
        chk("rst_busy", busy, 0);
        cnt_ovf = 1'b1;
        step(3);
        chk("idle_busy", busy, 0);
        chk("idle_clr", cnt_clr, 0);
        cnt_ovf = 1'b0;

        // Basic measurement with absolute timeline
        run = 1'b1;
        t0  = cyc;
        step();
        chk("basic_clr_cycle", cyc - t0, 1);
        attempt(1'b0, 1'b0, 1'b0);
        chk("basic_period", cyc - t0, 110);

        // Up-range 0 -> 1 -> 2, then publish
        attempt(1'b1, 1'b0, 1'b0);
        attempt(1'b1, 1'b0, 1'b0);
        attempt(1'b0, 1'b0, 1'b0);

        // Saturated overflow, then both flags high at range 2
        attempt(1'b1, 1'b0, 1'b0);
        attempt(1'b1, 1'b1, 1'b0);

        // Down-range 2 -> 1 -> 0, then publish at 0
        attempt(1'b0, 1'b1, 1'b0);
        attempt(1'b0, 1'b1, 1'b0);
        attempt(1'b0, 1'b1, 1'b0);

        // Anti-hunt: up-step then low must publish at current range
        attempt(1'b1, 1'b0, 1'b0);
        attempt(1'b0, 1'b1, 1'b0);

        // Randomized decide verdicts
        for (int i = 0; i < 12; i++) begin
            r_ovf = 1'($urandom);
            r_low = 1'($urandom);
            attempt(r_ovf, r_low, 1'b0);
        end

        // Drop run mid-gate: completes, then goes idle
        attempt(1'b0, 1'b0, 1'b1);
        step(5);
        chk("stop_busy", busy, 0);
        chk("stop_clr", cnt_clr, 0);
        chk("stop_valid_count", mv_count, m_pub);

        // Reset during GATE after reaching a non-zero range
        run = 1'b1;
        step();
        attempt(1'b1, 1'b0, 1'b0);
        chk("pre_rst_range_nonzero", (range != 2'd0), 1);
        step(4);
        chk("pre_rst_gate", cnt_en, 1);
        rst = 1'b1;
        run = 1'b0;
        step();
        rst = 1'b0;
        m_range = 0;
        m_up    = 1'b0;
        m_ovr   = 1'b0;
        chk("rst_gate_en", cnt_en, 0);
        chk("rst_gate_range", range, 0);
        chk("rst_gate_busy", busy, 0);
        chk("rst_gate_ovr", overrange, 0);
        step(10);
        chk("rst_gate_no_valid", mv_count, m_pub);
        chk("rst_gate_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
